// File: rtl/alu_operand_entry_pkg.sv
// Shared encodings for the operand-entry block: entry states, ALU opcodes and
// the default debounce length (sized for a 100 MHz clock, roughly 10 ms).
package alu_pkg;

  typedef enum logic [1:0] {
    ENTER_A  = 2'b00,
    ENTER_B  = 2'b01,
    ENTER_OP = 2'b10,
    HOLD     = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    AND = 2'b10,
    OR  = 2'b11
  } alu_op_e;

  localparam int DEBOUNCE_DEFAULT = 1_000_000;

endpackage

// File: rtl/alu_operand_entry_if.sv
// Switch/button inputs, consumer acknowledge and the operation outputs of the
// operand-entry block, grouped into one bundle.
interface alu_operand_entry_if;
  logic [4:0]        sw;
  logic              btn_enter;
  logic              btn_back;
  logic              ack;
  logic signed [4:0] a;
  logic signed [4:0] b;
  logic [1:0]        ALUControl;
  logic              valid;
  logic [1:0]        stage;

  modport master (
    output sw, btn_enter, btn_back, ack,
    input  a, b, ALUControl, valid, stage
  );

  modport slave (
    input  sw, btn_enter, btn_back, ack,
    output a, b, ALUControl, valid, stage
  );
endinterface

// File: rtl/alu_operand_entry_btn_debounce.sv
// Two-flop synchroniser, counter debouncer and rising-edge detector for one
// raw push-button; emits a single-cycle press pulse.
module btn_debounce
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  localparam int            CW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  // The pulse fires on the same edge the accepted level rises, so release
  // edges and a held button never produce a second pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == LIMIT) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_pulse <= r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign pulse = r_pulse;

endmodule

// File: rtl/alu_operand_entry.sv
// Steps through entry of operand A, operand B and the opcode from slide
// switches, then holds the completed operation until it is acknowledged.
module alu_operand_entry
  import alu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_operand_entry_if.slave   bus
);

  logic w_enter_pulse;
  logic w_back_pulse;
  logic w_enter;
  logic w_back;

  state_e            r_state;
  logic signed [4:0] r_a;
  logic signed [4:0] r_b;
  alu_op_e           r_op;
  logic              r_valid;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_enter),
    .pulse (w_enter_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_back),
    .pulse (w_back_pulse)
  );

  // Coincident enter and back presses cancel each other out.
  assign w_enter = w_enter_pulse & ~w_back_pulse;
  assign w_back  = w_back_pulse  & ~w_enter_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ENTER_A;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= ADD;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ENTER_A: begin
          if (w_enter) begin
            r_a     <= signed'(bus.sw);
            r_state <= ENTER_B;
          end
        end
        ENTER_B: begin
          if (w_enter) begin
            r_b     <= signed'(bus.sw);
            r_state <= ENTER_OP;
          end else if (w_back) begin
            r_state <= ENTER_A;
          end
        end
        ENTER_OP: begin
          if (w_enter) begin
            r_op    <= alu_op_e'(bus.sw[1:0]);
            r_valid <= 1'b1;
            r_state <= HOLD;
          end else if (w_back) begin
            r_state <= ENTER_B;
          end
        end
        HOLD: begin
          if (w_enter) begin
            r_valid <= 1'b0;
            r_state <= ENTER_A;
          end else if (w_back) begin
            r_valid <= 1'b0;
            r_state <= ENTER_OP;
          end else if (r_valid && bus.ack) begin
            r_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.a          = r_a;
  assign bus.b          = r_b;
  assign bus.ALUControl = r_op;
  assign bus.valid      = r_valid;
  assign bus.stage      = r_state;

endmodule

// File: tb/tb_alu_operand_entry.sv
// Bench for alu_operand_entry with a short debounce: directed table,
// bounce/glitch/reset corner sequences and a randomized operation-level model.
module tb_alu_operand_entry;

  localparam int D = 4;
  localparam int ACT_ENTER = 0;
  localparam int ACT_BACK  = 1;
  localparam int ACT_ACK   = 2;
  localparam int ACT_BOTH  = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  alu_operand_entry_if bus ();

  alu_operand_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         act;
    logic [4:0] sw;
    logic [1:0] st;
    logic [4:0] a;
    logic [4:0] b;
    logic [1:0] op;
    logic       v;
  } vec_t;

  vec_t tbl [14];

  // Operation-level reference state
  int         rm_st;
  logic [4:0] rm_a, rm_b;
  logic [1:0] rm_op;
  logic       rm_v;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int st, input logic [4:0] a,
                           input logic [4:0] b, input logic [1:0] op, input logic v);
    chk({tag, ".stage"}, 32'(bus.stage), 32'(st));
    chk({tag, ".a"}, 32'($unsigned(bus.a)), 32'(a));
    chk({tag, ".b"}, 32'($unsigned(bus.b)), 32'(b));
    chk({tag, ".op"}, 32'(bus.ALUControl), 32'(op));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(v));
  endtask

  task automatic do_action(input int act, input logic [4:0] s);
    bus.sw = s;
    if (act == ACT_ACK) begin
      bus.ack = 1'b1;
      step(1);
      bus.ack = 1'b0;
      step(2);
    end else begin
      bus.btn_enter = (act == ACT_ENTER) || (act == ACT_BOTH);
      bus.btn_back  = (act == ACT_BACK)  || (act == ACT_BOTH);
      step(12);
      bus.btn_enter = 1'b0;
      bus.btn_back  = 1'b0;
      step(12);
    end
  endtask

  function automatic void model(input int act, input logic [4:0] s);
    if (act == ACT_ENTER) begin
      case (rm_st)
        0: begin rm_a = s; rm_st = 1; end
        1: begin rm_b = s; rm_st = 2; end
        2: begin rm_op = s[1:0]; rm_st = 3; rm_v = 1'b1; end
        default: begin rm_st = 0; rm_v = 1'b0; end
      endcase
    end else if (act == ACT_BACK) begin
      if (rm_st != 0) begin
        rm_st = rm_st - 1;
        rm_v  = 1'b0;
      end
    end else if (act == ACT_ACK) begin
      rm_v = 1'b0;
    end
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [1:0] old_st;

    bus.sw = '0; bus.btn_enter = 1'b0; bus.btn_back = 1'b0; bus.ack = 1'b0;

    tbl[0]  = '{ACT_ENTER, 5'b00011, 2'd1, 5'b00011, 5'b00000, 2'd0, 1'b0};
    tbl[1]  = '{ACT_ENTER, 5'b11110, 2'd2, 5'b00011, 5'b11110, 2'd0, 1'b0};
    tbl[2]  = '{ACT_ENTER, 5'b00001, 2'd3, 5'b00011, 5'b11110, 2'd1, 1'b1};
    tbl[3]  = '{ACT_BOTH,  5'b00110, 2'd3, 5'b00011, 5'b11110, 2'd1, 1'b1};
    tbl[4]  = '{ACT_ACK,   5'b00110, 2'd3, 5'b00011, 5'b11110, 2'd1, 1'b0};
    tbl[5]  = '{ACT_ACK,   5'b00110, 2'd3, 5'b00011, 5'b11110, 2'd1, 1'b0};
    tbl[6]  = '{ACT_BACK,  5'b00110, 2'd2, 5'b00011, 5'b11110, 2'd1, 1'b0};
    tbl[7]  = '{ACT_BACK,  5'b00110, 2'd1, 5'b00011, 5'b11110, 2'd1, 1'b0};
    tbl[8]  = '{ACT_ENTER, 5'b00101, 2'd2, 5'b00011, 5'b00101, 2'd1, 1'b0};
    tbl[9]  = '{ACT_ENTER, 5'b00010, 2'd3, 5'b00011, 5'b00101, 2'd2, 1'b1};
    tbl[10] = '{ACT_ENTER, 5'b01111, 2'd0, 5'b00011, 5'b00101, 2'd2, 1'b0};
    tbl[11] = '{ACT_BACK,  5'b01111, 2'd0, 5'b00011, 5'b00101, 2'd2, 1'b0};
    tbl[12] = '{ACT_BOTH,  5'b01111, 2'd0, 5'b00011, 5'b00101, 2'd2, 1'b0};
    tbl[13] = '{ACT_ENTER, 5'b10000, 2'd1, 5'b10000, 5'b00101, 2'd2, 1'b0};

    // Reset state
    step(3);
    chk_state("reset", 0, 5'd0, 5'd0, 2'd0, 1'b0);
    reset = 1'b1;
    step(3);
    chk_state("post_reset", 0, 5'd0, 5'd0, 2'd0, 1'b0);

    for (int i = 0; i < 14; i++) begin
      do_action(tbl[i].act, tbl[i].sw);
      chk_state($sformatf("vec%0d", i), int'(tbl[i].st), tbl[i].a, tbl[i].b,
                tbl[i].op, tbl[i].v);
    end

    // Press latency from a clean rising edge
    reset = 1'b0; step(2); reset = 1'b1; step(2);
    old_st = bus.stage;
    bus.sw = 5'b00111;
    bus.btn_enter = 1'b1;
    n = 0;
    while (bus.stage == old_st && n < 20) begin
      step(1);
      n++;
    end
    tests++;
    if (n < D + 1 || n > D + 5) begin
      fails++;
      $display("FAIL latency: got %0d cycles expected %0d..%0d", n, D + 1, D + 5);
    end
    step(12);
    bus.btn_enter = 1'b0;
    step(12);
    chk_state("latency", 1, 5'b00111, 5'd0, 2'd0, 1'b0);

    // Short high, then a bouncing edge that settles high: one press only
    reset = 1'b0; step(2); reset = 1'b1; step(2);
    bus.sw = 5'b01010;
    bus.btn_enter = 1'b1;
    step(2);
    for (int i = 0; i < 10; i++) begin
      bus.btn_enter = (i % 2 == 1);
      step(1);
    end
    step(12);
    bus.btn_enter = 1'b0;
    step(12);
    chk_state("bounce", 1, 5'b01010, 5'd0, 2'd0, 1'b0);

    // Glitch one cycle shorter than the debounce window
    bus.sw = 5'b00100;
    bus.btn_enter = 1'b1;
    step(D - 1);
    bus.btn_enter = 1'b0;
    step(15);
    chk_state("glitch", 1, 5'b01010, 5'd0, 2'd0, 1'b0);

    // Reset while the enter button is mid-debounce
    bus.btn_enter = 1'b1;
    step(3);
    reset = 1'b0;
    #1;
    chk_state("async_reset", 0, 5'd0, 5'd0, 2'd0, 1'b0);
    bus.btn_enter = 1'b0;
    step(2);
    reset = 1'b1;
    step(15);
    chk_state("reset_release", 0, 5'd0, 5'd0, 2'd0, 1'b0);

    // Randomized operations against the reference model
    rm_st = 0; rm_a = '0; rm_b = '0; rm_op = '0; rm_v = 1'b0;
    for (int i = 0; i < 40; i++) begin
      int act;
      logic [4:0] s;
      act = int'($urandom_range(0, 3));
      s   = 5'($urandom);
      do_action(act, s);
      model(act, s);
      chk_state($sformatf("rand%0d", i), rm_st, rm_a, rm_b, rm_op, rm_v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
